dxm_rosc_sel_ctrl: RTL and testbench
====================================

Name: dxm_rosc_sel_ctrl

Overview:
- Sequencer for the TRNG entropy-source clock mux (dxm_mux_clk): selects one of NUM_SRC ring-oscillator sources, sequences the oscillator gating, settle window and sampling window, then reports completion.
- Sits between the TRNG register/control FSM and the source mux plus sampling logic.
- Guarantees the mux select never changes while the oscillator is enabled or while sampling is active.

Parameters:
- NUM_SRC, 4, number of selectable oscillator sources (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_SRC.
- CNT_W, 16, width of the sample-length counter.
- GUARD_CYCLES, 2, cycles with rosc_en low after a select change (>=1).
- SETTLE_CYCLES, 16, cycles with rosc_en high before sampling (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_req  in  1  level request to run one selection/sample sequence.
- src_req  in  SEL_W  requested source index; captured on acceptance.
- sample_len  in  CNT_W  sampling window length in cycles; captured on acceptance.
- abort  in  1  terminate the current sequence.
- start_ack  out  1  one-cycle pulse: request accepted.
- start_err  out  1  one-cycle pulse: request rejected because src_req >= NUM_SRC.
- busy  out  1  high in any state other than IDLE.
- mux_sel  out  SEL_W  drives the clock-mux control.
- rosc_en  out  1  oscillator enable.
- sample_en  out  1  sampling-window enable.
- done  out  1  one-cycle pulse: sequence completed normally.
- aborted  out  1  one-cycle pulse: sequence terminated by abort.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; mux_sel=0; rosc_en, sample_en, busy, start_ack, start_err, done and aborted all 0.
- All outputs are registered. Counters are cleared on every state entry.
- IDLE:
  - start_req=1 and src_req<NUM_SRC: capture src_req and sample_len; go to GUARD. Next cycle start_ack=1 and mux_sel equals the captured source.
  - start_req=1 and src_req>=NUM_SRC: start_err pulses next cycle; stay in IDLE; mux_sel unchanged.
  - start_req is sampled only in IDLE. The requester must drop it after start_ack, or it is re-accepted on return to IDLE.
- GUARD: rosc_en=0, sample_en=0. Lasts GUARD_CYCLES cycles, then go to SETTLE.
- SETTLE: rosc_en=1, sample_en=0. Lasts SETTLE_CYCLES cycles.
  - Exit to SAMPLE if the captured sample_len != 0.
  - Exit to DONE if the captured sample_len == 0 (sample_en never asserts).
- SAMPLE: rosc_en=1, sample_en=1. Lasts exactly the captured sample_len cycles (1..2^CNT_W-1), counted with a down-counter; then go to DONE.
- DONE: one cycle with done=1, rosc_en=0, sample_en=0; then go to IDLE.
- mux_sel is written only on acceptance in IDLE. It holds its value after DONE, after abort and across IDLE.
- Abort:
  - abort=1 in GUARD, SETTLE or SAMPLE: next cycle state is IDLE, rosc_en=0, sample_en=0, aborted=1, done=0.
  - abort has priority over any transition in the same cycle.
  - abort in IDLE or DONE is ignored. A sequence whose DONE cycle is reached completes normally.
  - abort=1 and start_req=1 together in IDLE: the request is accepted and abort is ignored.
- Latency from start_req sampled to the first sample_en cycle: 1 + GUARD_CYCLES + SETTLE_CYCLES cycles.
- busy=1 from the start_ack cycle through the DONE cycle inclusive. busy=0 on the aborted cycle.
- Reset mid-sequence: all outputs return to reset values immediately (asynchronous assert); operation resumes in IDLE after deassertion.
- Invariants (assert in verification):
  - sample_en implies rosc_en.
  - mux_sel is stable whenever rosc_en=1.
  - At most one of done, aborted, start_err is high in any cycle.

Decomposition:
- Shared package dxm_rosc_pkg holds:
  - the state encoding (IDLE, GUARD, SETTLE, SAMPLE, DONE);
  - default constants for GUARD_CYCLES and SETTLE_CYCLES;
  - the SEL_W derivation from NUM_SRC.
- One natural sub-module: dxm_dncnt, a loadable down-counter with a zero flag. It is instanced once and shared by the GUARD, SETTLE and SAMPLE phases.
- The FSM and output registers stay in the top level.

Test Plan:
- Reset, then start_req with src_req=2, sample_len=5 (defaults): start_ack at cycle 1; mux_sel=2 from cycle 1; rosc_en rises at cycle 3; sample_en high cycles 19..23; done at cycle 24; busy low at cycle 25.
- src_req=5 with NUM_SRC=4: start_err single pulse; mux_sel keeps its previous value; busy stays 0; no start_ack.
- sample_len=0, src_req=1: sample_en never asserts; done follows the last SETTLE cycle; rosc_en high exactly 16 cycles.
- abort on the 3rd SAMPLE cycle of a sample_len=10 run: next cycle aborted=1, rosc_en=0, sample_en=0, state IDLE; done never pulses; mux_sel retained.
- start_req held high across DONE: a second start_ack arrives the cycle after return to IDLE, with freshly captured src_req and sample_len.
- rst_n asserted during SETTLE: all outputs go to 0 asynchronously; after release, a new request runs the full GUARD and SETTLE sequence again.

Source files
------------

// File: rtl/dxm_rosc_pkg.sv
// Shared types and defaults for the ring-oscillator select sequencer.
// State encoding, default phase lengths and select-width derivation.
package dxm_rosc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GUARD  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_GUARD_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 16;

    function automatic int sel_width(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/dxm_dncnt.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Latency: loaded value visible the cycle after i_load; no backpressure.
module dxm_dncnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dxm_rosc_sel_ctrl.sv
// TRNG oscillator select sequencer: IDLE -> GUARD -> SETTLE -> [SAMPLE] -> DONE.
// All outputs registered (1-cycle request-to-ack); abort returns to IDLE next cycle.
module dxm_rosc_sel_ctrl
    import dxm_rosc_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int SEL_W         = sel_width(NUM_SRC),
    parameter int CNT_W         = 16,
    parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_req,
    input  logic [SEL_W-1:0] src_req,
    input  logic [CNT_W-1:0] sample_len,
    input  logic             abort,
    output logic             start_ack,
    output logic             start_err,
    output logic             busy,
    output logic [SEL_W-1:0] mux_sel,
    output logic             rosc_en,
    output logic             sample_en,
    output logic             done,
    output logic             aborted
);

    localparam logic [SEL_W:0] LP_NUM_SRC = (SEL_W+1)'(NUM_SRC);

    state_t           r_state;
    state_t           w_nxt;
    logic [CNT_W-1:0] r_len;
    logic [SEL_W-1:0] r_sel;
    logic             r_ack, r_err, r_busy, r_rosc, r_samp, r_done, r_abt;
    logic             w_acc, w_rej, w_abt;
    logic             w_load, w_zero;
    logic [CNT_W-1:0] w_load_val;

    always_comb begin
        w_nxt = r_state;
        w_acc = 1'b0;
        w_rej = 1'b0;
        w_abt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_req) begin
                    if ({1'b0, src_req} < LP_NUM_SRC) begin
                        w_acc = 1'b1;
                        w_nxt = ST_GUARD;
                    end else begin
                        w_rej = 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (abort) begin
                    w_abt = 1'b1;
                    w_nxt = ST_IDLE;
                end else if (w_zero) begin
                    w_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_abt = 1'b1;
                    w_nxt = ST_IDLE;
                end else if (w_zero) begin
                    w_nxt = (r_len != '0) ? ST_SAMPLE : ST_DONE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_abt = 1'b1;
                    w_nxt = ST_IDLE;
                end else if (w_zero) begin
                    w_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    // Counter is reloaded with (phase length - 1) on every state entry.
    always_comb begin
        w_load     = (w_nxt != r_state);
        w_load_val = '0;
        case (w_nxt)
            ST_GUARD:  w_load_val = CNT_W'(GUARD_CYCLES - 1);
            ST_SETTLE: w_load_val = CNT_W'(SETTLE_CYCLES - 1);
            ST_SAMPLE: w_load_val = r_len - CNT_W'(1);
            default:   w_load_val = '0;
        endcase
    end

    dxm_dncnt #(
        .W (CNT_W)
    ) u_dncnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rosc  <= 1'b0;
            r_samp  <= 1'b0;
            r_done  <= 1'b0;
            r_abt   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_acc) begin
                r_sel <= src_req;
                r_len <= sample_len;
            end
            r_ack  <= w_acc;
            r_err  <= w_rej;
            r_abt  <= w_abt;
            r_busy <= (w_nxt != ST_IDLE);
            r_rosc <= (w_nxt == ST_SETTLE) || (w_nxt == ST_SAMPLE);
            r_samp <= (w_nxt == ST_SAMPLE);
            r_done <= (w_nxt == ST_DONE);
        end
    end

    assign start_ack = r_ack;
    assign start_err = r_err;
    assign busy      = r_busy;
    assign mux_sel   = r_sel;
    assign rosc_en   = r_rosc;
    assign sample_en = r_samp;
    assign done      = r_done;
    assign aborted   = r_abt;

endmodule

// File: tb/tb_dxm_rosc_sel_ctrl.sv
// Testbench for dxm_rosc_sel_ctrl: directed scenarios plus randomized sequences
// checked against a timeline model derived from the phase lengths.
module tb_dxm_rosc_sel_ctrl;

    localparam int NSRC = 4;
    localparam int SW   = 3;
    localparam int CW   = 16;
    localparam int G    = 2;
    localparam int S    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_req = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] src_req = '0;
    logic [CW-1:0] sample_len = '0;
    logic          start_ack, start_err, busy, rosc_en, sample_en, done, aborted;
    logic [SW-1:0] mux_sel;
    logic [SW+6:0] obs;

    int total = 0;
    int bad   = 0;
    logic [SW-1:0] cur_sel = '0;

    always #5 clk = ~clk;

    dxm_rosc_sel_ctrl #(
        .NUM_SRC       (NSRC),
        .SEL_W         (SW),
        .CNT_W         (CW),
        .GUARD_CYCLES  (G),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_req  (start_req),
        .src_req    (src_req),
        .sample_len (sample_len),
        .abort      (abort),
        .start_ack  (start_ack),
        .start_err  (start_err),
        .busy       (busy),
        .mux_sel    (mux_sel),
        .rosc_en    (rosc_en),
        .sample_en  (sample_en),
        .done       (done),
        .aborted    (aborted)
    );

    assign obs = {start_ack, start_err, busy, rosc_en, sample_en, done, aborted, mux_sel};

    // Cycle t counts from the request edge: ack at 1, done at 1+G+S+len.
    function automatic int done_cyc(input int len);
        return 1 + G + S + len;
    endfunction

    function automatic int end_cyc(input int len, input int ab);
        int d;
        d = done_cyc(len);
        return (ab > 0 && ab < d) ? ab + 1 : d + 1;
    endfunction

    function automatic logic [SW+6:0] exp_acc(input int t, input int src, input int len, input int ab);
        int   d;
        logic ack, bsy, ro, sa, dn, ab_o;
        d = done_cyc(len);
        ack = 1'b0; bsy = 1'b0; ro = 1'b0; sa = 1'b0; dn = 1'b0; ab_o = 1'b0;
        if (ab > 0 && ab < d && t > ab) begin
            ab_o = (t == ab + 1);
        end else begin
            ack = (t == 1);
            bsy = (t >= 1 && t <= d);
            ro  = (t >= 1 + G && t < d);
            sa  = (t >= 1 + G + S && t < d);
            dn  = (t == d);
        end
        return {ack, 1'b0, bsy, ro, sa, dn, ab_o, SW'(src)};
    endfunction

    function automatic logic [SW+6:0] exp_rej(input int t, input logic [SW-1:0] prev);
        return {1'b0, (t == 1), 5'b0, prev};
    endfunction

    task automatic test_reset();
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, {(SW+7){1'b0}}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_idle got=%b exp=%b", obs, {(SW+7){1'b0}}); end
    endtask

    task automatic test_basic();
        logic [SW+6:0] ex;
        start_req = 1'b1; src_req = 3'd2; sample_len = 16'd5;
        for (int t = 1; t <= end_cyc(5, -1); t++) begin
            @(negedge clk);
            start_req = 1'b0;
            ex = exp_acc(t, 2, 5, -1);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL basic t=%0d got=%b exp=%b", t, obs, ex); end
        end
        cur_sel = 3'd2;
    endtask

    task automatic test_reject();
        logic [SW+6:0] ex;
        start_req = 1'b1; src_req = 3'd5; sample_len = 16'd3;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            start_req = 1'b0;
            ex = exp_rej(t, cur_sel);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL reject t=%0d got=%b exp=%b", t, obs, ex); end
        end
    endtask

    task automatic test_zero_len();
        logic [SW+6:0] ex;
        int ro_cnt;
        ro_cnt = 0;
        // abort together with an IDLE request must be ignored
        start_req = 1'b1; src_req = 3'd1; sample_len = 16'd0; abort = 1'b1;
        for (int t = 1; t <= end_cyc(0, 0); t++) begin
            @(negedge clk);
            start_req = 1'b0; abort = 1'b0;
            ex = exp_acc(t, 1, 0, 0);
            if (rosc_en) ro_cnt++;
            total++;
            if (obs !== ex) begin bad++; $display("FAIL zero_len t=%0d got=%b exp=%b", t, obs, ex); end
        end
        total++;
        if (ro_cnt != S) begin bad++; $display("FAIL zero_len_rosc_cycles got=%0d exp=%0d", ro_cnt, S); end
        cur_sel = 3'd1;
    endtask

    task automatic test_abort();
        logic [SW+6:0] ex;
        int ab;
        ab = 1 + G + S + 2;
        start_req = 1'b1; src_req = 3'd3; sample_len = 16'd10;
        for (int t = 1; t <= end_cyc(10, ab) + 2; t++) begin
            @(negedge clk);
            start_req = 1'b0;
            abort = (t == ab);
            ex = exp_acc(t, 3, 10, ab);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL abort t=%0d got=%b exp=%b", t, obs, ex); end
        end
        abort = 1'b0;
        cur_sel = 3'd3;
    endtask

    task automatic test_back_to_back();
        logic [SW+6:0] ex;
        int d1;
        d1 = done_cyc(3);
        start_req = 1'b1; src_req = 3'd0; sample_len = 16'd3;
        for (int t = 1; t <= d1 + 1; t++) begin
            @(negedge clk);
            ex = exp_acc(t, 0, 3, -1);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs, ex); end
            if (t == d1) begin src_req = 3'd3; sample_len = 16'd7; end
        end
        for (int t = 1; t <= end_cyc(7, -1); t++) begin
            @(negedge clk);
            start_req = 1'b0;
            ex = exp_acc(t, 3, 7, -1);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs, ex); end
        end
        cur_sel = 3'd3;
    endtask

    task automatic test_reset_mid();
        logic [SW+6:0] ex;
        start_req = 1'b1; src_req = 3'd1; sample_len = 16'd2;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            start_req = 1'b0;
            ex = exp_acc(t, 1, 2, -1);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL rstmid_pre t=%0d got=%b exp=%b", t, obs, ex); end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL rstmid_async got=%b exp=%b", obs, {(SW+7){1'b0}}); end
        @(negedge clk);
        rst_n = 1'b1;
        cur_sel = '0;
        @(negedge clk);
        total++;
        if (obs !== '0) begin bad++; $display("FAIL rstmid_idle got=%b exp=%b", obs, {(SW+7){1'b0}}); end
        start_req = 1'b1; src_req = 3'd2; sample_len = 16'd1;
        for (int t = 1; t <= end_cyc(1, -1); t++) begin
            @(negedge clk);
            start_req = 1'b0;
            ex = exp_acc(t, 2, 1, -1);
            total++;
            if (obs !== ex) begin bad++; $display("FAIL rstmid_post t=%0d got=%b exp=%b", t, obs, ex); end
        end
        cur_sel = 3'd2;
    endtask

    task automatic test_random();
        logic [SW+6:0] ex;
        int src, len, ab, gap, n;
        for (int it = 0; it < 40; it++) begin
            src = int'($urandom_range(0, 7));
            len = int'($urandom_range(0, 24));
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, done_cyc(len))) : -1;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            start_req = 1'b1; src_req = SW'(src); sample_len = CW'(len); abort = (ab == 0);
            n = (src >= NSRC) ? 2 : end_cyc(len, ab);
            for (int t = 1; t <= n; t++) begin
                @(negedge clk);
                start_req = 1'b0;
                abort = (src < NSRC) && (t == ab);
                ex = (src >= NSRC) ? exp_rej(t, cur_sel) : exp_acc(t, src, len, ab);
                total++;
                if (obs !== ex) begin
                    bad++;
                    $display("FAIL random it=%0d t=%0d src=%0d len=%0d ab=%0d got=%b exp=%b",
                             it, t, src, len, ab, obs, ex);
                end
                total++;
                if ((sample_en && !rosc_en) || (int'(done) + int'(aborted) + int'(start_err) > 1)) begin
                    bad++;
                    $display("FAIL random_invariant it=%0d t=%0d got=%b exp=%s", it, t, obs, "sample_en->rosc_en, <=1 status pulse");
                end
            end
            abort = 1'b0;
            if (src < NSRC) cur_sel = SW'(src);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
